// File: rtl/adder_operand_loader.sv
// adder_operand_loader
// Captures two operands from a shared pin bus. Each rising edge of the load
// strobe captures one operand. When both operands are held, they are offered
// to a downstream adder with a valid/ready handshake.
//
// Build option: define LOADER_SYNC_EN to pass 'load' through a two-flop
// synchronizer before the edge detector. Use this when 'load' comes from an
// unrelated clock or from a pin. When the macro is undefined, 'load' must
// already be synchronous to clk.
module adder_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             overrun,
  output logic [7:0]       txn_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // Conditioned load level: synchronized or raw, depending on the build.
  logic w_load_cond;

`ifdef LOADER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for an asynchronous load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= load;
      r_sync2 <= r_sync1;
    end
  end

  assign w_load_cond = r_sync2;
`else
  assign w_load_cond = load;
`endif

  // Edge detector.
  // r_ld samples the conditioned level, and r_ld_d remembers its previous
  // value. A held-high level therefore yields exactly one pulse.
  logic r_ld;
  logic r_ld_d;
  logic w_ld_evt;

  // Register the conditioned load level and its one-cycle-delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld   <= 1'b0;
      r_ld_d <= 1'b0;
    end else begin
      r_ld   <= w_load_cond;
      r_ld_d <= r_ld;
    end
  end

  assign w_ld_evt = r_ld & ~r_ld_d;

  // Architectural state.
  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_valid;
  logic             r_overrun;
  logic [7:0]       r_txn_count;

  // Next-state values.
  state_t           w_state_next;
  logic [WIDTH-1:0] w_op_a_next;
  logic [WIDTH-1:0] w_op_b_next;
  logic             w_op_valid_next;
  logic             w_overrun_next;
  logic [7:0]       w_txn_count_next;

  // State and datapath register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_txn_count <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_op_a      <= w_op_a_next;
      r_op_b      <= w_op_b_next;
      r_op_valid  <= w_op_valid_next;
      r_overrun   <= w_overrun_next;
      r_txn_count <= w_txn_count_next;
    end
  end

  // Next-state and datapath decode.
  // clear beats everything, except that txn_count is kept.
  always_comb begin
    w_state_next     = r_state;
    w_op_a_next      = r_op_a;
    w_op_b_next      = r_op_b;
    w_op_valid_next  = r_op_valid;
    w_overrun_next   = r_overrun;
    w_txn_count_next = r_txn_count;

    if (clear) begin
      w_state_next    = S_IDLE;
      w_op_a_next     = '0;
      w_op_b_next     = '0;
      w_op_valid_next = 1'b0;
      w_overrun_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ld_evt) begin
            w_op_a_next  = din;
            w_state_next = S_GOT_A;
          end
        end

        S_GOT_A: begin
          if (w_ld_evt) begin
            w_op_b_next     = din;
            w_op_valid_next = 1'b1;
            w_state_next    = S_VALID;
          end
        end

        S_VALID: begin
          if (op_ready) begin
            // Handshake completes.
            // A load edge arriving in the same cycle starts the next pair,
            // so no edge is lost.
            w_op_valid_next  = 1'b0;
            w_txn_count_next = r_txn_count + 8'd1;
            if (w_ld_evt) begin
              w_op_a_next  = din;
              w_state_next = S_GOT_A;
            end else begin
              w_state_next = S_IDLE;
            end
          end else if (w_ld_evt) begin
            // No room for a third operand.
            // Drop the edge and flag it until cleared.
            w_overrun_next = 1'b1;
          end
        end

        default: begin
          // Encoding 2'd3 is unreachable; recover to IDLE.
          w_state_next    = S_IDLE;
          w_op_valid_next = 1'b0;
        end
      endcase
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_valid  = r_op_valid;
  assign overrun   = r_overrun;
  assign txn_count = r_txn_count;
  assign state     = r_state;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Testbench for adder_operand_loader.
// It supports either build, with or without LOADER_SYNC_EN.
module tb_adder_operand_loader;

  localparam int W = 8;
`ifdef LOADER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         load;
  logic         clear;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_valid;
  logic         overrun;
  logic [7:0]   txn_count;
  logic [1:0]   state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_txn;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  adder_operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .load      (load),
    .clear     (clear),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .overrun   (overrun),
    .txn_count (txn_count),
    .state     (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle load pulse. Returns after the capture edge has passed.
  task automatic load_edge(input logic [7:0] d);
    tick();
    din  = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic transaction(input logic [7:0] a, input logic [7:0] b);
    load_edge(a);
    load_edge(b);
    sb_q.push_back({a, b});
    handshake();
  endtask

  // Scoreboard: every completed handshake must match the oldest expected pair.
  always @(negedge clk) begin
    logic [15:0] want;
    if (!rst && op_valid && op_ready && !clear) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: handshake op_a=%h op_b=%h with empty queue", op_a, op_b);
      end else begin
        want = sb_q.pop_front();
        $display("txn %0d: op_a=%h op_b=%h", txn_count, op_a, op_b);
        chk("sb_op_a", 32'(op_a), 32'(want[15:8]));
        chk("sb_op_b", 32'(op_b), 32'(want[7:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{a: 8'h01, b: 8'h02, exp_txn: 8'd1};
    tbl[1] = '{a: 8'hFF, b: 8'h00, exp_txn: 8'd2};
    tbl[2] = '{a: 8'h80, b: 8'h7F, exp_txn: 8'd3};
    tbl[3] = '{a: 8'hAA, b: 8'h55, exp_txn: 8'd4};
    tbl[4] = '{a: 8'h00, b: 8'hFF, exp_txn: 8'd5};
    tbl[5] = '{a: 8'h3C, b: 8'hC3, exp_txn: 8'd6};

    rst      = 1'b1;
    din      = '0;
    load     = 1'b0;
    clear    = 1'b0;
    op_ready = 1'b0;

    // Reset values are asserted before any clock edge.
    #1;
    chk("rst_state",    32'(state),     32'd0);
    chk("rst_op_valid", 32'(op_valid),  32'd0);
    chk("rst_txn",      32'(txn_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_op_a",     32'(op_a),      32'd0);
    chk("rst_op_b",     32'(op_b),      32'd0);
    chk("rst_overrun",  32'(overrun),   32'd0);

    // Two loads, no ready. The pair is held stable.
    load_edge(8'h12);
    chk("gota_state", 32'(state), 32'd1);
    chk("gota_valid", 32'(op_valid), 32'd0);
    load_edge(8'h34);
    for (int i = 0; i < 10; i++) begin
      chk("hold_op_a",  32'(op_a),     32'h12);
      chk("hold_op_b",  32'(op_b),     32'h34);
      chk("hold_valid", 32'(op_valid), 32'd1);
      chk("hold_state", 32'(state),    32'd2);
      tick();
    end

    // Single-cycle handshake.
    sb_q.push_back({8'h12, 8'h34});
    handshake();
    chk("hs_valid", 32'(op_valid),  32'd0);
    chk("hs_txn",   32'(txn_count), 32'd1);
    chk("hs_state", 32'(state),     32'd0);

    // Handshake and a new load edge in the same cycle.
    load_edge(8'h56);
    load_edge(8'h78);
    sb_q.push_back({8'h56, 8'h78});
    din  = 8'hA5;
    load = 1'b1;
    repeat (LAT) tick();
    op_ready = 1'b1;
    load     = 1'b0;
    tick();
    op_ready = 1'b0;
    chk("simul_txn",     32'(txn_count), 32'd2);
    chk("simul_state",   32'(state),     32'd1);
    chk("simul_op_a",    32'(op_a),      32'hA5);
    chk("simul_overrun", 32'(overrun),   32'd0);
    chk("simul_valid",   32'(op_valid),  32'd0);
    load_edge(8'h5A);
    sb_q.push_back({8'hA5, 8'h5A});
    handshake();
    chk("simul2_txn", 32'(txn_count), 32'd3);

    // Overrun in VALID, then clear together with a handshake attempt.
    load_edge(8'hC3);
    load_edge(8'h3C);
    load_edge(8'hFF);
    chk("ovr_flag",  32'(overrun), 32'd1);
    chk("ovr_op_a",  32'(op_a),    32'hC3);
    chk("ovr_op_b",  32'(op_b),    32'h3C);
    chk("ovr_state", 32'(state),   32'd2);
    repeat (3) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clear    = 1'b1;
    op_ready = 1'b1;
    tick();
    clear    = 1'b0;
    op_ready = 1'b0;
    chk("clr_state",   32'(state),     32'd0);
    chk("clr_overrun", 32'(overrun),   32'd0);
    chk("clr_valid",   32'(op_valid),  32'd0);
    chk("clr_op_a",    32'(op_a),      32'd0);
    chk("clr_op_b",    32'(op_b),      32'd0);
    chk("clr_txn",     32'(txn_count), 32'd3);

    // op_ready outside VALID has no effect.
    op_ready = 1'b1;
    repeat (3) tick();
    op_ready = 1'b0;
    chk("rdy_idle_txn",   32'(txn_count), 32'd3);
    chk("rdy_idle_state", 32'(state),     32'd0);

    // Load held high for 20 cycles gives one capture.
    tick();
    din  = 8'h77;
    load = 1'b1;
    repeat (20) tick();
    load = 1'b0;
    repeat (LAT + 2) tick();
    chk("held_state", 32'(state),    32'd1);
    chk("held_op_a",  32'(op_a),     32'h77);
    chk("held_valid", 32'(op_valid), 32'd0);
    load_edge(8'h88);
    sb_q.push_back({8'h77, 8'h88});
    handshake();
    chk("held_txn", 32'(txn_count), 32'd4);

    // Asynchronous reset in GOT_A, with load held high through release.
    load_edge(8'h11);
    chk("pre_rst_state", 32'(state), 32'd1);
    @(negedge clk);
    #2;
    rst  = 1'b1;
    din  = 8'h66;
    load = 1'b1;
    #1;
    chk("arst_state", 32'(state),     32'd0);
    chk("arst_op_a",  32'(op_a),      32'd0);
    chk("arst_op_b",  32'(op_b),      32'd0);
    chk("arst_valid", 32'(op_valid),  32'd0);
    chk("arst_txn",   32'(txn_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (LAT) tick();
    chk("lat_not_early", 32'(state), 32'd0);
    tick();
    chk("lat_capture",  32'(state), 32'd1);
    chk("lat_op_a",     32'(op_a),  32'h66);
    load = 1'b0;
    load_edge(8'h22);
    sb_q.push_back({8'h66, 8'h22});
    handshake();
    chk("post_rst_txn", 32'(txn_count), 32'd1);

    // Table vectors from reset, then fill to 256 transactions.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst2_txn", 32'(txn_count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      load_edge(tbl[i].a);
      load_edge(tbl[i].b);
      chk("tbl_op_a",  32'(op_a),     32'(tbl[i].a));
      chk("tbl_op_b",  32'(op_b),     32'(tbl[i].b));
      chk("tbl_valid", 32'(op_valid), 32'd1);
      sb_q.push_back({tbl[i].a, tbl[i].b});
      handshake();
      chk("tbl_txn",   32'(txn_count), 32'(tbl[i].exp_txn));
      chk("tbl_state", 32'(state),     32'd0);
    end
    for (int i = 6; i < 255; i++) begin
      transaction(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    chk("txn_255", 32'(txn_count), 32'd255);
    transaction(8'h9E, 8'hE9);
    chk("txn_wrap", 32'(txn_count), 32'd0);

    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_operand_loader.md
ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port din  input  WIDTH  operand data from the pin bus.
REQ-005 The block SHALL have port load  input  1  asynchronous capture strobe (level, rising edge meaningful).
REQ-006 The block SHALL have port clear  input  1  synchronous abort.
REQ-007 The block SHALL have port op_a  output  WIDTH  captured first operand to the downstream adder.
REQ-008 The block SHALL have port op_b  output  WIDTH  captured second operand to the downstream adder.
REQ-009 The block SHALL have port op_valid  output  1  operand pair valid.
REQ-010 The block SHALL have port op_ready  input  1  downstream adder accepts the pair.
REQ-011 The block SHALL have port overrun  output  1  sticky: load edge lost.
REQ-012 The block SHALL have port txn_count  output  8  completed handshakes, wrapping.
REQ-013 The block SHALL have port state  output  2  FSM state, debug.

Function
REQ-014 Edge pulse ld_evt SHALL be high for exactly one cycle per rising edge of the conditioned load signal (see Configuration); a held-high load SHALL yield one pulse.
REQ-015 din SHALL be sampled in the same cycle ld_evt is high; din is required stable from the load edge until capture.
REQ-016 FSM states: IDLE=2'd0, GOT_A=2'd1, VALID=2'd2; 2'd3 unreachable, SHALL return to IDLE next cycle.
REQ-017 IDLE + ld_evt: op_a <= din, go to GOT_A.
REQ-018 GOT_A + ld_evt: op_b <= din, op_valid <= 1, go to VALID; op_valid and op_b update in the same cycle.
REQ-019 VALID: op_a, op_b, op_valid SHALL hold stable until op_valid && op_ready.
REQ-020 VALID + op_ready, no ld_evt: op_valid <= 0, txn_count <= txn_count+1 (255 wraps to 0), go to IDLE.
REQ-021 VALID + op_ready + ld_evt same cycle: handshake completes as REQ-020, and op_a <= din, go to GOT_A (no edge lost).
REQ-022 VALID + ld_evt, no op_ready: edge discarded, overrun <= 1, operands unchanged.
REQ-023 op_ready outside VALID SHALL have no effect.
REQ-024 clear SHALL override all other inputs: state <= IDLE, op_valid <= 0, op_a/op_b <= 0, overrun <= 0; txn_count unchanged; same-cycle ld_evt and handshake discarded (txn_count not incremented).
REQ-025 overrun SHALL clear only by clear or rst.

Reset
REQ-026 rst high SHALL immediately, without a clock, force state=IDLE, op_a=0, op_b=0, op_valid=0, overrun=0, txn_count=0, and all synchronizer/edge flops to 0.
REQ-027 Reset mid-transaction SHALL discard any captured operand; a load held high through reset release SHALL produce one ld_evt after release.
REQ-028 Reset deassertion is required synchronous to clk upstream of this block.

Configuration
REQ-029 Macro LOADER_SYNC_EN defined: load SHALL pass through a two-flop synchronizer before edge detect; ld_evt asserts in the 3rd cycle after the first clk edge that samples load high.
REQ-030 LOADER_SYNC_EN undefined: no synchronizer; ld_evt asserts in the cycle after the first clk edge that samples load high (single delay flop edge detect); load is required synchronous to clk.
REQ-031 All other behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset, din=8'h12 load pulse, din=8'h34 load pulse, op_ready=0 -> op_a=8'h12, op_b=8'h34, op_valid=1, state=2, held 10 cycles.
REQ-033 From REQ-032 state, op_ready=1 one cycle -> op_valid=0 next cycle, txn_count=1, state=0.
REQ-034 In VALID, op_ready=1 and ld_evt same cycle with din=8'hA5 -> txn_count increments, state=1, op_a=8'hA5, overrun=0.
REQ-035 In VALID, op_ready=0, third load pulse din=8'hFF -> overrun=1, op_a/op_b unchanged; then clear -> state=0, overrun=0, op_valid=0.
REQ-036 256 complete transactions from reset -> txn_count=0; load held high 20 cycles -> exactly one capture.
REQ-037 Assert rst asynchronously in GOT_A between clk edges -> outputs zero before next clk edge; check ld_evt latency 3 cycles with LOADER_SYNC_EN, 1 cycle without.
